// File: rtl/psimd_addsub_if.sv
//-----------------------------------------------------------------------------
// psimd_addsub_if
//
// Bundle of handshake and data signals for the packed-SIMD add/subtract unit.
//
//   Input side  : in_valid, in_ready, a, b, sub, sat
//   Output side : out_valid, out_ready, result, lane_ovfl
//   Status      : sticky_ovfl, clr_sticky
//
// Modports
//   master : the agent that feeds operands and consumes results
//   slave  : the arithmetic unit itself
//
// DATA_W and LANE_W must match the parameters of the psimd_addsub instance
// the interface is connected to.
//-----------------------------------------------------------------------------
interface psimd_addsub_if #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4
);
  localparam int LANES = DATA_W / LANE_W;

  // Operand side
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              sub;
  logic              sat;

  // Result side
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [LANES-1:0]  lane_ovfl;

  // Sticky overflow status
  logic [LANES-1:0]  sticky_ovfl;
  logic              clr_sticky;

  modport master (
    output in_valid, a, b, sub, sat, out_ready, clr_sticky,
    input  in_ready, out_valid, result, lane_ovfl, sticky_ovfl
  );

  modport slave (
    input  in_valid, a, b, sub, sat, out_ready, clr_sticky,
    output in_ready, out_valid, result, lane_ovfl, sticky_ovfl
  );

endinterface : psimd_addsub_if

// File: rtl/psimd_addsub.sv
//-----------------------------------------------------------------------------
// psimd_addsub
//
// Pipelined packed-SIMD add/subtract unit. A DATA_W word is split into
// LANES = DATA_W/LANE_W independent signed lanes. Each lane computes A+B or
// A-B with either two's-complement wrap or signed saturation, and reports a
// per-lane signed overflow flag. Overflow flags are also OR-accumulated into
// a sticky status register that software clears explicitly.
//
// Pipeline: two registered stages, 2-cycle latency, 1 beat/cycle throughput.
//   S1 : captures a, b, sub, sat on the input handshake
//   S2 : holds the computed result and lane_ovfl, presented downstream
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   bus (slave)  : psimd_addsub_if
//     in_valid / in_ready    operand handshake
//     a, b                   packed operands, lane i = [i*LANE_W +: LANE_W]
//     sub                    0: A+B, 1: A-B (per lane)
//     sat                    1: saturate on overflow, 0: wrap
//     out_valid / out_ready  result handshake
//     result                 packed lane results
//     lane_ovfl              per-lane overflow of the presented result
//     sticky_ovfl            OR of lane_ovfl over accepted results
//     clr_sticky             synchronous clear of sticky_ovfl
//
// Parameters
//   DATA_W : total width, must be a multiple of LANE_W
//   LANE_W : lane width, 2..DATA_W
//-----------------------------------------------------------------------------
module psimd_addsub #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  psimd_addsub_if.slave bus
);

  localparam int LANES = DATA_W / LANE_W;

  //---------------------------------------------------------------------------
  // Pipeline state
  //---------------------------------------------------------------------------
  // S1 (operand stage)
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_a;
  logic [DATA_W-1:0] r_s1_b;
  logic              r_s1_sub;
  logic              r_s1_sat;

  // S2 (result stage)
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_result;
  logic [LANES-1:0]  r_lane_ovfl;

  // Status
  logic [LANES-1:0]  r_sticky;

  //---------------------------------------------------------------------------
  // Flow control
  //---------------------------------------------------------------------------
  logic w_s2_can_load;
  logic w_in_ready;
  logic w_in_fire;
  logic w_out_fire;

  // S2 accepts new content when it is empty or its current beat is leaving.
  assign w_s2_can_load = !r_s2_valid || bus.out_ready;

  // S1 can take a beat when empty or when its beat moves into S2 this cycle.
  // Depends only on registers and out_ready, never on in_valid, so upstream
  // may compute in_valid from in_ready without a combinational loop.
  assign w_in_ready    = !r_s1_valid || w_s2_can_load;

  assign w_in_fire     = bus.in_valid && w_in_ready;
  assign w_out_fire    = r_s2_valid && bus.out_ready;

  //---------------------------------------------------------------------------
  // Lane arithmetic on S1 contents
  //---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_result;
  logic [LANES-1:0]  w_lane_ovfl;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] w_a;
    logic [LANE_W-1:0] w_b_eff;
    logic [LANE_W-1:0] w_sum;
    logic              w_ovfl;
    logic [LANE_W-1:0] w_sat_val;

    assign w_a     = r_s1_a[gi*LANE_W +: LANE_W];

    // Subtraction is A + ~B + 1 inside the lane; the +1 enters as the lane's
    // own carry-in so nothing propagates across lane boundaries.
    assign w_b_eff = r_s1_sub ? ~r_s1_b[gi*LANE_W +: LANE_W]
                              :  r_s1_b[gi*LANE_W +: LANE_W];
    assign w_sum   = w_a + w_b_eff + {{(LANE_W-1){1'b0}}, r_s1_sub};

    // Comparing against the effective (possibly inverted) B covers both
    // cases: add overflows on equal signs of A and B, subtract on differing
    // signs, and in both cases only if the result sign departs from A.
    assign w_ovfl  = (w_a[LANE_W-1] == w_b_eff[LANE_W-1]) &&
                     (w_sum[LANE_W-1] != w_a[LANE_W-1]);

    // Saturation direction follows the sign of A: a non-negative A can only
    // overflow upward, a negative A only downward.
    assign w_sat_val = w_a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}}
                                     : {1'b0, {(LANE_W-1){1'b1}}};

    assign w_result[gi*LANE_W +: LANE_W] = (r_s1_sat && w_ovfl) ? w_sat_val
                                                                : w_sum;
    assign w_lane_ovfl[gi] = w_ovfl;
  end : g_lane

  //---------------------------------------------------------------------------
  // S1 operand registers
  //---------------------------------------------------------------------------
  // NOTE: pure datapath registers carry no reset; their contents are only
  // consumed while r_s1_valid is set, and that flag is reset.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_a   <= bus.a;
      r_s1_b   <= bus.b;
      r_s1_sub <= bus.sub;
      r_s1_sat <= bus.sat;
    end
  end

  //---------------------------------------------------------------------------
  // Control, S2 and status registers
  //---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_result    <= '0;
      r_lane_ovfl <= '0;
      r_sticky    <= '0;
    end else begin
      // S1 occupancy: fill on input handshake, drain when S2 takes the beat.
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_can_load) begin
        r_s1_valid <= 1'b0;
      end

      // S2: only overwrite the data when a real beat arrives so the last
      // result stays visible while idle and stable while stalled.
      if (w_s2_can_load) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_result    <= w_result;
          r_lane_ovfl <= w_lane_ovfl;
        end
      end

      // Sticky: a clear coinciding with a handshake keeps that beat's flags
      // so the overflow event is not lost.
      if (bus.clr_sticky) begin
        r_sticky <= w_out_fire ? r_lane_ovfl : '0;
      end else if (w_out_fire) begin
        r_sticky <= r_sticky | r_lane_ovfl;
      end
    end
  end

  //---------------------------------------------------------------------------
  // Outputs
  //---------------------------------------------------------------------------
  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_s2_valid;
  assign bus.result      = r_result;
  assign bus.lane_ovfl   = r_lane_ovfl;
  assign bus.sticky_ovfl = r_sticky;

endmodule : psimd_addsub

// File: tb/tb_psimd_addsub.sv
//-----------------------------------------------------------------------------
// tb_psimd_addsub
//
// Two instances: 16-bit / 4-bit lanes (directed cases, backpressure, sticky,
// randomized traffic against an integer-arithmetic reference) and
// 16-bit / 8-bit lanes (wide-lane case and reset in the middle of operation).
//-----------------------------------------------------------------------------
module tb_psimd_addsub;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] ovfl;
  } exp_t;

  logic clk;
  logic rst_n4;
  logic rst_n8;

  int n_tests;
  int n_fail;

  psimd_addsub_if #(.DATA_W(16), .LANE_W(4)) if4 ();
  psimd_addsub_if #(.DATA_W(16), .LANE_W(8)) if8 ();

  psimd_addsub #(.DATA_W(16), .LANE_W(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n4),
    .bus   (if4.slave)
  );

  psimd_addsub #(.DATA_W(16), .LANE_W(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n8),
    .bus   (if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: signed integer arithmetic per lane, then range check.
  function automatic exp_t ref_op(input logic [15:0] a, input logic [15:0] b,
                                  input logic sub, input logic sat,
                                  input int lw);
    exp_t e;
    int   mask, va, vb, r, mx, mn;
    e    = '0;
    mask = (1 << lw) - 1;
    mx   = (1 << (lw - 1)) - 1;
    mn   = -(1 << (lw - 1));
    for (int i = 0; i < 16 / lw; i++) begin
      va = int'(a >> (i * lw)) & mask;
      vb = int'(b >> (i * lw)) & mask;
      if (va > mx) va -= (1 << lw);
      if (vb > mx) vb -= (1 << lw);
      r = sub ? va - vb : va + vb;
      if (r > mx || r < mn) begin
        e.ovfl[i] = 1'b1;
        if (sat) r = (r > mx) ? mx : mn;
      end
      e.res = e.res | 16'((r & mask) << (i * lw));
    end
    return e;
  endfunction

  // Directed beat on the 4-lane unit with the sink always ready.
  task automatic send4(input string tag, input logic [15:0] a,
                       input logic [15:0] b, input logic sub, input logic sat,
                       input logic [15:0] exp_res, input logic [3:0] exp_ov);
    int lat;
    @(negedge clk);
    if4.a = a; if4.b = b; if4.sub = sub; if4.sat = sat;
    if4.in_valid = 1'b1; if4.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, if4.in_ready, 1'b1);
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if4.in_valid = 1'b0;
      #1;
      if (if4.out_valid) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_result"}, if4.result, exp_res);
    check({tag, "_ovfl"}, if4.lane_ovfl, exp_ov);
  endtask

  // Randomized traffic state
  exp_t       exp_q[$];
  logic [3:0] sticky_m;
  logic       pending;

  task automatic rnd_cycle(input bit drain);
    exp_t       e;
    logic [3:0] e_ov;
    @(negedge clk);
    if (drain) begin
      if4.in_valid = 1'b0;
      if4.out_ready = 1'b1;
      if4.clr_sticky = 1'b0;
    end else begin
      if (!pending) begin
        if4.in_valid = ($urandom_range(0, 3) != 0);
        if4.a   = 16'($urandom);
        if4.b   = 16'($urandom);
        if4.sub = 1'($urandom);
        if4.sat = 1'($urandom);
      end
      if4.out_ready  = ($urandom_range(0, 3) != 0);
      if4.clr_sticky = ($urandom_range(0, 15) == 0);
    end
    #1;
    check("rnd_sticky", if4.sticky_ovfl, sticky_m);
    check("rnd_in_ready", if4.in_ready, (exp_q.size() < 2) || if4.out_ready);
    e_ov = '0;
    if (if4.out_valid && if4.out_ready) begin
      check("rnd_out_queued", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rnd_result", if4.result, e.res);
        check("rnd_ovfl", if4.lane_ovfl, e.ovfl);
        e_ov = e.ovfl[3:0];
      end
    end
    if (if4.in_valid && if4.in_ready) begin
      exp_q.push_back(ref_op(if4.a, if4.b, if4.sub, if4.sat, 4));
      pending = 1'b0;
    end else begin
      pending = if4.in_valid;
    end
    if (if4.clr_sticky) sticky_m = e_ov;
    else                sticky_m = sticky_m | e_ov;
  endtask

  logic [15:0] bp_a [3];
  logic [15:0] bp_exp [3];
  logic [15:0] held;
  int          idx, n_out, first_c, last_c, any_ready, ov_seen, lat8;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bp_a    = '{16'h1111, 16'h2222, 16'h0001};
    bp_exp  = '{16'h2222, 16'h3333, 16'h1112};

    {if4.in_valid, if4.out_ready, if4.clr_sticky, if4.sub, if4.sat} = '0;
    {if8.in_valid, if8.out_ready, if8.clr_sticky, if8.sub, if8.sat} = '0;
    if4.a = '0; if4.b = '0; if8.a = '0; if8.b = '0;
    rst_n4 = 1'b0;
    rst_n8 = 1'b0;
    #12;
    check("rst_out_valid", if4.out_valid, 1'b0);
    check("rst_result", if4.result, 16'h0000);
    check("rst_lane_ovfl", if4.lane_ovfl, 4'h0);
    check("rst_sticky", if4.sticky_ovfl, 4'h0);
    check("rst8_out_valid", if8.out_valid, 1'b0);
    @(negedge clk);
    rst_n4 = 1'b1;
    rst_n8 = 1'b1;
    #1;
    check("rst_in_ready", if4.in_ready, 1'b1);

    // Directed lane arithmetic
    send4("sat_add",  16'h7123, 16'h1111, 1'b0, 1'b1, 16'h7234, 4'b1000);
    send4("wrap_add", 16'h7123, 16'h1111, 1'b0, 1'b0, 16'h8234, 4'b1000);
    send4("neg_add",  16'h8000, 16'hF000, 1'b0, 1'b1, 16'h8000, 4'b1000);
    send4("sat_sub",  16'h0800, 16'h0100, 1'b1, 1'b1, 16'h0800, 4'b0100);
    send4("plain_sub", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 4'b0000);

    // Idle hold
    repeat (3) @(negedge clk);
    #1;
    check("idle_out_valid", if4.out_valid, 1'b0);
    check("idle_result", if4.result, 16'h0002);

    // Sticky clear / accumulate / clear-with-handshake
    @(negedge clk); if4.clr_sticky = 1'b1;
    @(negedge clk); if4.clr_sticky = 1'b0; #1;
    check("stk_clr_idle0", if4.sticky_ovfl, 4'b0000);
    @(negedge clk);
    if4.a = 16'h7123; if4.b = 16'h1111; if4.sub = 1'b0; if4.sat = 1'b1;
    if4.in_valid = 1'b1; if4.out_ready = 1'b1;
    @(negedge clk);
    if4.a = 16'h0007; if4.b = 16'h0001;
    @(negedge clk);
    if4.in_valid = 1'b0; #1;
    check("stk_b1_ovfl", if4.lane_ovfl, 4'b1000);
    @(negedge clk);
    if4.clr_sticky = 1'b1; #1;
    check("stk_after_b1", if4.sticky_ovfl, 4'b1000);
    check("stk_b2_ovfl", if4.lane_ovfl, 4'b0001);
    @(negedge clk); #1;
    check("stk_clr_hs", if4.sticky_ovfl, 4'b0001);
    @(negedge clk);
    if4.clr_sticky = 1'b0; #1;
    check("stk_clr_alone", if4.sticky_ovfl, 4'b0000);

    // Backpressure: 3 beats offered with the sink stalled
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if4.out_ready = 1'b0; if4.in_valid = 1'b1;
      if4.a = bp_a[idx]; if4.b = 16'h1111; if4.sub = 1'b0; if4.sat = 1'b0;
      #1;
      if (if4.in_ready) idx++;
    end
    check("bp_accepted", idx, 2);
    check("bp_in_ready", if4.in_ready, 1'b0);
    check("bp_out_valid", if4.out_valid, 1'b1);
    held = if4.result;
    any_ready = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (if4.in_ready) any_ready++;
      if (if4.result !== held) check("bp_stable", if4.result, held);
    end
    check("bp_stall_ready", any_ready, 0);
    check("bp_hold", if4.result, bp_exp[0]);
    n_out = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if4.out_ready = 1'b1;
      if4.in_valid  = (idx < 3);
      if (idx < 3) if4.a = bp_a[idx];
      #1;
      if (if4.out_valid) begin
        if (n_out < 3) check("bp_order", if4.result, bp_exp[n_out]);
        if (first_c < 0) first_c = c;
        last_c = c;
        n_out++;
      end
      if (if4.in_valid && if4.in_ready) idx++;
    end
    if4.in_valid = 1'b0;
    check("bp_count", n_out, 3);
    check("bp_back_to_back", last_c - first_c, 2);

    // Randomized traffic against the reference model
    @(negedge clk); if4.clr_sticky = 1'b1; if4.out_ready = 1'b1;
    @(negedge clk); if4.clr_sticky = 1'b0;
    sticky_m = '0;
    pending  = 1'b0;
    for (int c = 0; c < 500; c++) rnd_cycle(1'b0);
    for (int c = 0; c < 10; c++)  rnd_cycle(1'b1);
    check("rnd_drained", exp_q.size(), 0);

    // 8-bit lanes
    @(negedge clk);
    if8.a = 16'h7F01; if8.b = 16'h0101; if8.sub = 1'b0; if8.sat = 1'b1;
    if8.in_valid = 1'b1; if8.out_ready = 1'b1;
    lat8 = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if8.in_valid = 1'b0;
      #1;
      if (if8.out_valid) begin
        lat8 = c;
        break;
      end
    end
    check("l8_latency", lat8, 2);
    check("l8_result", if8.result, 16'h7F02);
    check("l8_ovfl", if8.lane_ovfl, 2'b10);

    // Reset with a beat sitting in S1
    @(negedge clk);
    if8.a = 16'h0102; if8.b = 16'h0304; if8.sat = 1'b0; if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    #1;
    check("l8_sticky_before_rst", if8.sticky_ovfl, 2'b10);
    rst_n8 = 1'b0;
    #1;
    check("l8_rst_out_valid", if8.out_valid, 1'b0);
    check("l8_rst_result", if8.result, 16'h0000);
    check("l8_rst_ovfl", if8.lane_ovfl, 2'b00);
    check("l8_rst_sticky", if8.sticky_ovfl, 2'b00);
    repeat (2) @(negedge clk);
    rst_n8 = 1'b1;
    ov_seen = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (if8.out_valid) ov_seen++;
    end
    check("l8_no_ghost_beat", ov_seen, 0);
    check("l8_in_ready", if8.in_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_psimd_addsub
